// File: rtl/trace_pkg.sv
// Shared types and default constants for the instruction trace transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package trace_pkg;

    // One trace record: fetch PC, fetched instruction, cycle stamp (80 bits)
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [15:0] cycle;
    } trace_rec_t;

    localparam int REC_W = $bits(trace_rec_t);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } trace_state_t;

    localparam int          DEF_FIFO_DEPTH       = 8;
    localparam logic [31:0] DEF_TRACE_ADDR_LIMIT = 32'h60;
    localparam logic [31:0] DEF_DONE_ADDR        = 32'h300;
    localparam logic [15:0] DEF_TIMEOUT_CYCLES   = 16'd200;

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO holding trace records.
// Latency: a pushed entry is visible on pop_dat the cycle after the push edge.
// Backpressure: push is refused when full unless a pop happens the same cycle.
// Ports: clk/rst_n; push/push_dat write side; pop/pop_dat read side
//        (pop_dat is the head, forced to 0 while empty); full/empty status.
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 80
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the slot on the same edge, so a push into a full FIFO proceeds
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    // Head is zeroed while empty so the outputs read 0 after reset
    assign pop_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/instr_trace_tx.sv
// Snoops CPU fetches, records new in-range PCs and streams them out until the run ends.
// Latency: a record is presented on trace_* the cycle after its capture edge.
// Backpressure: valid/ready; records hold while not ready, captures into a full buffer are dropped and counted.
// Ports: clk/rst_n; i_mem_*/d_mem_* snooped CPU buses; trace_valid/trace_ready with
//        trace_pc/trace_instr/trace_cycle record; drop_count, done, timed_out status.
module instr_trace_tx
    import trace_pkg::*;
#(
    parameter int          FIFO_DEPTH       = DEF_FIFO_DEPTH,
    parameter logic [31:0] TRACE_ADDR_LIMIT = DEF_TRACE_ADDR_LIMIT,
    parameter logic [31:0] DONE_ADDR        = DEF_DONE_ADDR,
    parameter logic [15:0] TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_rdata,
    input  logic [31:0] d_mem_addr,
    input  logic [31:0] d_mem_wdata,
    input  logic [3:0]  d_mem_wen,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_instr,
    output logic [15:0] trace_cycle,
    output logic [7:0]  drop_count,
    output logic        done,
    output logic        timed_out
);

    trace_state_t state;
    trace_state_t state_nxt;
    logic [15:0]  cycle_cnt;
    logic [31:0]  last_pc;
    logic         in_run;
    logic         capture;
    logic         end_marker;
    logic         timeout_hit;
    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_pop;
    trace_rec_t   cap_rec;
    trace_rec_t   head_rec;

    assign end_marker  = (d_mem_wen == 4'b1111) && (d_mem_addr == DONE_ADDR) &&
                         (d_mem_wdata == 32'h1);
    assign timeout_hit = (cycle_cnt == TIMEOUT_CYCLES);
    // A stalled fetch (same PC) is recorded once; capture uses the pre-edge state
    // so the fetch on the RUN->DRAIN edge is still recorded
    assign capture     = in_run && (i_mem_addr != last_pc) && (i_mem_addr < TRACE_ADDR_LIMIT);
    assign fifo_pop    = trace_valid && trace_ready;

    assign cap_rec.pc    = i_mem_addr;
    assign cap_rec.instr = i_mem_rdata;
    assign cap_rec.cycle = cycle_cnt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (end_marker || timeout_hit) state_nxt = ST_DRAIN;
            ST_DRAIN: if (fifo_empty)                state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_DONE;
            default:  state_nxt = ST_RUN;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        in_run = (state == ST_RUN);
        done   = (state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt  <= 16'd0;
            last_pc    <= 32'hFFFF_FFFF;
            drop_count <= 8'd0;
            timed_out  <= 1'b0;
        end else begin
            if (in_run) cycle_cnt <= cycle_cnt + 16'd1;
            if (capture) last_pc <= i_mem_addr;
            if (capture && fifo_full && !fifo_pop && (drop_count != 8'hFF))
                drop_count <= drop_count + 8'd1;
            // End marker beats a coincident timeout
            if (in_run && (end_marker || timeout_hit))
                timed_out <= !end_marker;
        end
    end

    trace_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (capture),
        .push_dat (cap_rec),
        .pop      (fifo_pop),
        .pop_dat  (head_rec),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign trace_valid = !fifo_empty;
    assign trace_pc    = head_rec.pc;
    assign trace_instr = head_rec.instr;
    assign trace_cycle = head_rec.cycle;

endmodule
